// File: rtl/mul_pkg.sv
// Op encodings and result-select helpers shared by the multiplier issue wrapper.
package mul_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    MUL_W    = 2'd0,
    MULH_W   = 2'd1,
    MULH_WU  = 2'd2,
    MUL_RSVD = 2'd3
  } mul_op_e;

  // The reserved encoding falls through to the low half, matching MUL_W.
  function automatic logic [31:0] mul_sel(input logic [OP_W-1:0] op,
                                          input logic [63:0]     product);
    logic [31:0] res;
    case (op)
      MULH_W, MULH_WU: res = product[63:32];
      default:         res = product[31:0];
    endcase
    return res;
  endfunction

  function automatic logic mul_is_signed(input logic [OP_W-1:0] op);
    return op != MULH_WU;
  endfunction

endpackage

// File: rtl/mul_res_fifo.sv
// Result FIFO behind the multiplier; head is read straight from storage and
// reads as zero whenever the FIFO is empty.
module mul_res_fifo
  import mul_pkg::*;
#(
  parameter int W     = 37,
  parameter int DEPTH = 3
) (
  input  logic                       mul_clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Flush wins over a same-cycle push so results of flushed ops are dropped.
  always_ff @(posedge mul_clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge mul_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_valid = (cnt != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;
  assign count      = cnt;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/return control around the fixed-latency pipelined multiplier array:
// credit-based acceptance, in-flight tracking and an ordered result buffer.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int MUL_LAT = 1,
  parameter int TAG_W   = 5,
  parameter int DEPTH   = MUL_LAT + 2
) (
  input  logic             mul_clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mul_signed,
  output logic [31:0]      mul_x,
  output logic [31:0]      mul_y,
  input  logic [63:0]      mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int FW    = 32 + TAG_W;

  logic               fire;
  logic [MUL_LAT-1:0] stg_vld;
  logic [OP_W-1:0]    stg_op  [MUL_LAT];
  logic [TAG_W-1:0]   stg_tag [MUL_LAT];
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   inflight_count;
  logic [CNT_W:0]     credit_used;
  logic               push;
  logic               pop;
  logic [FW-1:0]      push_data;
  logic [FW-1:0]      head;

  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < MUL_LAT; i++) begin
      inflight_count = inflight_count + CNT_W'(stg_vld[i]);
    end
  end

  // Every accepted op owns a FIFO slot from issue until it is popped.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_count};
  assign in_ready    = resetn & ~flush & (credit_used < (CNT_W + 1)'(DEPTH));
  assign fire        = in_valid & in_ready;

  assign mul_x      = fire ? in_src1 : '0;
  assign mul_y      = fire ? in_src2 : '0;
  assign mul_signed = fire & mul_is_signed(in_op);

  always_ff @(posedge mul_clk) begin
    if (!resetn || flush) begin
      stg_vld <= '0;
    end else begin
      stg_vld[0] <= fire;
      for (int i = 1; i < MUL_LAT; i++) stg_vld[i] <= stg_vld[i-1];
    end
  end

  always_ff @(posedge mul_clk) begin
    stg_op[0]  <= in_op;
    stg_tag[0] <= in_tag;
    for (int i = 1; i < MUL_LAT; i++) begin
      stg_op[i]  <= stg_op[i-1];
      stg_tag[i] <= stg_tag[i-1];
    end
  end

  assign push      = stg_vld[MUL_LAT-1];
  assign push_data = {mul_sel(stg_op[MUL_LAT-1], mul_result), stg_tag[MUL_LAT-1]};
  assign pop       = out_valid & out_ready;

  mul_res_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .mul_clk    (mul_clk),
    .resetn     (resetn),
    .flush      (flush),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_valid (out_valid),
    .head_data  (head),
    .count      (fifo_count)
  );

  assign out_data = head[FW-1:TAG_W];
  assign out_tag  = head[TAG_W-1:0];

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: models the multiplier array, predicts acceptance,
// timing and ordering from an outstanding-op queue, and checks every cycle.
module tb_mul_issue_ctrl;

  localparam int MUL_LAT = 1;
  localparam int TAG_W   = 5;
  localparam int DEPTH   = MUL_LAT + 2;

  logic             mul_clk = 1'b0;
  logic             resetn = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = '0;
  logic [31:0]      in_src1 = '0;
  logic [31:0]      in_src2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             mul_signed;
  logic [31:0]      mul_x;
  logic [31:0]      mul_y;
  logic [63:0]      mul_result = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  mul_issue_ctrl #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .mul_clk    (mul_clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .mul_signed (mul_signed),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag)
  );

  always #5 mul_clk = ~mul_clk;

  function automatic logic [63:0] arr_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] ea, eb;
    logic signed [65:0] p;
    ea = $signed({s & a[31], a});
    eb = $signed({s & b[31], b});
    p  = ea * eb;
    return p[63:0];
  endfunction

  // Multiplier array with MUL_LAT = 1.
  always @(posedge mul_clk) mul_result <= arr_prod(mul_signed, mul_x, mul_y);

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] ea, eb;
    logic signed [65:0] p;
    ea = (op == 2'd2) ? $signed({1'b0, a}) : $signed({a[31], a});
    eb = (op == 2'd2) ? $signed({1'b0, b}) : $signed({b[31], b});
    p  = ea * eb;
    return (op == 2'd1 || op == 2'd2) ? p[63:32] : p[31:0];
  endfunction

  typedef struct {
    logic [31:0]      d;
    logic [TAG_W-1:0] t;
    int               rdy;
  } ent_t;

  ent_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  int          fails = 0;
  int          rst_run = 0;
  int          acc = 0;
  logic        kn_en = 1'b0;
  logic [31:0] kn_val = '0;
  logic [4:0]  tag_ctr = '0;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", nm, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    logic er, fire_e, eov;
    ent_t e;
    @(negedge mul_clk);
    er     = resetn && !flush && (q.size() < DEPTH);
    fire_e = er && in_valid;
    chk("in_ready", in_ready, er);
    chk("mul_x", mul_x, fire_e ? in_src1 : 32'h0);
    chk("mul_y", mul_y, fire_e ? in_src2 : 32'h0);
    chk("mul_signed", mul_signed, fire_e && (in_op != 2'd2));
    eov = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("out_valid", out_valid, eov);
    if (eov) begin
      chk("out_data", out_data, q[0].d);
      chk("out_tag", out_tag, q[0].t);
    end
    chk("fifo_count_bound", dut.fifo_count <= DEPTH, 1'b1);
    if (!resetn) begin
      if (rst_run > 0) begin
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_tag", out_tag, 0);
      end
      rst_run++;
    end else begin
      rst_run = 0;
    end
    if (in_valid && in_ready === 1'b1) acc++;
    if (eov && out_ready) void'(q.pop_front());
    if (!resetn || flush) q.delete();
    if (fire_e) begin
      e.d   = kn_en ? kn_val : ref_res(in_op, in_src1, in_src2);
      e.t   = in_tag;
      e.rdy = cyc + MUL_LAT + 1;
      q.push_back(e);
    end
    cyc++;
    @(posedge mul_clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic ordy, input logic fl, input logic rn);
    in_valid  = v;
    in_op     = op;
    in_src1   = a;
    in_src2   = b;
    in_tag    = tag_ctr;
    out_ready = ordy;
    flush     = fl;
    resetn    = rn;
    tag_ctr   = tag_ctr + 1'b1;
    tick();
  endtask

  task automatic rnd_step(input logic v, input logic ordy, input logic fl, input logic rn);
    step(v, 2'($urandom_range(0, 3)), $urandom, $urandom, ordy, fl, rn);
  endtask

  task automatic known(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    kn_en  = 1'b1;
    kn_val = exp;
    step(1'b1, op, a, b, 1'b1, 1'b0, 1'b1);
    kn_en  = 1'b0;
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'h0, 32'h0, ordy, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Directed ops with fixed expected results
    known(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    known(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    known(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    known(2'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF);
    known(2'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);

    // Back-to-back throughput
    for (int i = 0; i < 20; i++) rnd_step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Backpressure: only DEPTH ops accepted, then drain in order
    acc = 0;
    for (int i = 0; i < 10; i++) rnd_step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("bp_accepts", acc, DEPTH);
    for (int i = 0; i < 8; i++) rnd_step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Flush with two ops outstanding and an op presented during flush
    rnd_step(1'b1, 1'b0, 1'b0, 1'b1);
    rnd_step(1'b1, 1'b0, 1'b0, 1'b1);
    rnd_step(1'b1, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b0);
    rnd_step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Reset mid-operation with two results buffered
    rnd_step(1'b1, 1'b0, 1'b0, 1'b1);
    rnd_step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    for (int i = 0; i < 3; i++) rnd_step(1'b1, 1'b0, 1'b0, 1'b0);
    rnd_step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Random soak with occasional flushes
    for (int i = 0; i < 300; i++) begin
      rnd_step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 31) == 0), 1'b1);
    end
    idle(6, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
